// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg -- types and framing constants shared by the UART TX and RX engines.
// Rev 1.0
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// uart_sync_fifo -- single-clock byte FIFO with flush, occupancy count and flags.
// Rev 1.0
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [UART_DATA_BITS-1:0] wdata_i,
  output logic [UART_DATA_BITS-1:0] rdata_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             rd_ptr_q;
  logic [AW:0]               count_q;
  logic                      w_push;
  logic                      w_pop;

  // Flush wins over both ports; a push is refused while full even if a pop frees a slot.
  assign w_push  = push_i & ~full_o & ~flush_i;
  assign w_pop   = pop_i & ~empty_o & ~flush_i;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// uart_tx_engine -- FIFO-buffered 8N1 UART transmitter with drain interrupt.
// Rev 1.0
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int BAUD_DIV = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [UART_DATA_BITS-1:0] i_wr_data,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic                      i_fifo_rst,
  output logic                      o_tx,
  output logic                      o_fifo_empty,
  output logic                      o_fifo_full,
  output logic                      o_busy,
  output logic                      o_intr
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(BAUD_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIV - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [AW:0]               w_count;
  logic                      w_full;
  logic                      w_empty;
  logic [UART_DATA_BITS-1:0] w_head;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_drain;
  logic                      w_div_done;

  uart_state_e               state_q;
  logic [DW-1:0]             div_q;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      tx_q;
  logic                      drain_q;
  logic                      intr_q;

  assign o_wr_ready   = ~w_full & ~i_fifo_rst;
  assign w_push       = i_wr_valid & o_wr_ready;
  assign w_div_done   = (div_q == DIV_LAST);

  // A new frame is loaded from IDLE, or straight out of the last STOP cycle so frames abut.
  assign w_pop        = ~w_empty & ~i_fifo_rst &
                        ((state_q == ST_IDLE) || ((state_q == ST_STOP) && w_div_done));
  assign w_drain      = w_pop & (w_count == CNT_ONE) & ~w_push;

  assign o_tx         = tx_q;
  assign o_intr       = intr_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_fifo_empty = w_empty;
  assign o_fifo_full  = w_full;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (i_fifo_rst),
    .wdata_i (i_wr_data),
    .rdata_o (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // tx_q is driven from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      drain_q <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      drain_q <= w_drain;
      intr_q  <= drain_q;
      case (state_q)
        ST_IDLE: begin
          tx_q  <= UART_IDLE_LEVEL;
          div_q <= '0;
          bit_q <= '0;
          if (w_pop) begin
            shift_q <= w_head;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          tx_q <= UART_START_BIT;
          if (w_div_done) begin
            div_q   <= '0;
            state_q <= ST_DATA;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_DATA: begin
          tx_q <= shift_q[0];
          if (w_div_done) begin
            div_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
              state_q <= ST_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_STOP: begin
          tx_q <= UART_STOP_BIT;
          if (w_div_done) begin
            div_q <= '0;
            if (w_pop) begin
              shift_q <= w_head;
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule : uart_tx_engine
`default_nettype wire

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 16: TX FIFO depth in bytes; power of two, at least 2.
REQ-002 SHALL have parameter BAUD_DIV, default 16: i_clk cycles per serial bit; at least 2.
REQ-003 SHALL have port i_clk, input, 1 bit: clock; all logic on the rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_wr_data, input, 8 bits: byte from the register-write path (TX FIFO register).
REQ-006 SHALL have port i_wr_valid, input, 1 bit: i_wr_data is valid.
REQ-007 SHALL have port o_wr_ready, output, 1 bit: the FIFO can accept a byte.
REQ-008 SHALL have port i_fifo_rst, input, 1 bit: the control-register "reset TX FIFO" pulse.
REQ-009 SHALL have port o_tx, output, 1 bit: serial line; idles high.
REQ-010 SHALL have port o_fifo_empty, output, 1 bit: status bit, FIFO is empty.
REQ-011 SHALL have port o_fifo_full, output, 1 bit: status bit, FIFO is full.
REQ-012 SHALL have port o_busy, output, 1 bit: a frame is in flight.
REQ-013 SHALL have port o_intr, output, 1 bit: one-cycle pulse when the FIFO drains to empty.

Function
REQ-014 SHALL accept a byte on any rising edge where i_wr_valid and o_wr_ready are both high.
REQ-015 SHALL drive o_wr_ready as (not full) and (not i_fifo_rst), computed combinationally from the registered count.
REQ-016 SHALL keep a registered count of width log2(DEPTH)+1 bits, with o_fifo_full = (count == DEPTH) and o_fifo_empty = (count == 0).
REQ-017 SHALL let read and write pointers wrap modulo DEPTH; a simultaneous push and pop SHALL leave count unchanged.
REQ-018 SHALL never accept a push while full, even if a pop occurs on the same edge.
REQ-019 SHALL, when i_fifo_rst is high, zero count and both pointers on that edge, drop any concurrent push, and let an in-flight frame complete unaltered.
REQ-020 SHALL implement serializer FSM states IDLE, START, DATA, STOP.
REQ-021 SHALL, in IDLE with the FIFO non-empty, pop the head byte into a shift register and enter START on the same edge.
REQ-022 SHALL frame each byte as 8N1: START drives 0, DATA sends 8 bits LSB first, STOP drives 1; each bit lasts exactly BAUD_DIV cycles.
REQ-023 SHALL time bits with a divider counter (0..BAUD_DIV-1) and a 3-bit bit index; advance on a divider terminal count.
REQ-024 SHALL, on the final STOP cycle, go directly to START with a new pop if the FIFO is non-empty (no idle gap), else to IDLE.
REQ-025 SHALL make o_tx a registered output, so the first accepted byte into an idle, empty engine drives o_tx low exactly 2 cycles after the accepting edge.
REQ-026 SHALL make one frame occupy exactly 10*BAUD_DIV cycles of o_tx.
REQ-027 SHALL drive o_busy high in START, DATA and STOP, and low in IDLE.
REQ-028 SHALL pulse o_intr for one cycle on the edge after count transitions from 1 to 0 by a pop; a flush by i_fifo_rst SHALL NOT pulse o_intr.

Reset
REQ-029 SHALL, on reset, set: FSM IDLE; count, pointers, divider and bit index to 0; o_tx=1; o_busy=0; o_intr=0; o_fifo_empty=1; o_fifo_full=0; o_wr_ready=1 after reset deasserts.
REQ-030 SHALL, if reset asserts mid-frame, abort the frame and return o_tx high on the next edge; FIFO contents are discarded.
REQ-031 SHALL not reset the FIFO storage array.

Structure
REQ-032 SHALL place the FSM state enum, UART_DATA_BITS=8 and the frame-bit constants in shared package uart_pkg, reused by the RX counterpart.
REQ-033 SHALL implement the FIFO as sub-module uart_sync_fifo (parameter DEPTH, with push/pop/flush/count/full/empty); the serializer SHALL live in uart_tx_engine.

Verification (BAUD_DIV=4, DEPTH=16)
REQ-034 SHALL cover: write 0xA5 when idle -> o_tx low at cycle +2, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high; 40 cycles total; o_intr pulses once.
REQ-035 SHALL cover: write 0x00 and 0xFF back-to-back -> two contiguous 40-cycle frames with no idle cycle between them; o_busy high for 80 cycles.
REQ-036 SHALL cover: 17 writes while the first frame is sending -> 16 accepted; o_wr_ready low when full; the 17th is held until a pop, then accepted.
REQ-037 SHALL cover: assert i_fifo_rst with 5 bytes queued mid-frame -> current frame completes, no further frames, o_fifo_empty=1, no o_intr pulse.
REQ-038 SHALL cover: assert i_rst_n low during DATA -> o_tx=1, FSM IDLE, count 0 next cycle; a post-reset write of 0x3C transmits correctly.
REQ-039 SHALL cover: push and pop on the same edge with count=3 -> count stays 3; pointers wrap correctly after 20 cumulative bytes.
